// File: rtl/cc_matrix_row_writer_if.sv
// ============================================================================
// Module      : cc_matrix_row_writer_if
// Description : Command, row-stream handshake and matrix-row bundle of the
//               8x8 game-matrix row writer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cc_matrix_row_writer_if #(
    parameter int MATRIXROWWRITER_DATAWIDTH = 8
);
    logic                                 CC_MATRIXROWWRITER_start_InHigh;
    logic                                 CC_MATRIXROWWRITER_clear_InHigh;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] CC_MATRIXROWWRITER_data_InBUS;
    logic                                 CC_MATRIXROWWRITER_valid_InHigh;
    logic                                 CC_MATRIXROWWRITER_ready_OutHigh;
    logic                                 CC_MATRIXROWWRITER_busy_OutHigh;
    logic                                 CC_MATRIXROWWRITER_done_OutHigh;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] CC_MATRIXROWWRITER_registro0_OutBUS;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] CC_MATRIXROWWRITER_registro1_OutBUS;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] CC_MATRIXROWWRITER_registro2_OutBUS;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] CC_MATRIXROWWRITER_registro3_OutBUS;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] CC_MATRIXROWWRITER_registro4_OutBUS;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] CC_MATRIXROWWRITER_registro5_OutBUS;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] CC_MATRIXROWWRITER_registro6_OutBUS;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] CC_MATRIXROWWRITER_registro7_OutBUS;

    modport master (
        output CC_MATRIXROWWRITER_start_InHigh,
        output CC_MATRIXROWWRITER_clear_InHigh,
        output CC_MATRIXROWWRITER_data_InBUS,
        output CC_MATRIXROWWRITER_valid_InHigh,
        input  CC_MATRIXROWWRITER_ready_OutHigh,
        input  CC_MATRIXROWWRITER_busy_OutHigh,
        input  CC_MATRIXROWWRITER_done_OutHigh,
        input  CC_MATRIXROWWRITER_registro0_OutBUS,
        input  CC_MATRIXROWWRITER_registro1_OutBUS,
        input  CC_MATRIXROWWRITER_registro2_OutBUS,
        input  CC_MATRIXROWWRITER_registro3_OutBUS,
        input  CC_MATRIXROWWRITER_registro4_OutBUS,
        input  CC_MATRIXROWWRITER_registro5_OutBUS,
        input  CC_MATRIXROWWRITER_registro6_OutBUS,
        input  CC_MATRIXROWWRITER_registro7_OutBUS
    );

    modport slave (
        input  CC_MATRIXROWWRITER_start_InHigh,
        input  CC_MATRIXROWWRITER_clear_InHigh,
        input  CC_MATRIXROWWRITER_data_InBUS,
        input  CC_MATRIXROWWRITER_valid_InHigh,
        output CC_MATRIXROWWRITER_ready_OutHigh,
        output CC_MATRIXROWWRITER_busy_OutHigh,
        output CC_MATRIXROWWRITER_done_OutHigh,
        output CC_MATRIXROWWRITER_registro0_OutBUS,
        output CC_MATRIXROWWRITER_registro1_OutBUS,
        output CC_MATRIXROWWRITER_registro2_OutBUS,
        output CC_MATRIXROWWRITER_registro3_OutBUS,
        output CC_MATRIXROWWRITER_registro4_OutBUS,
        output CC_MATRIXROWWRITER_registro5_OutBUS,
        output CC_MATRIXROWWRITER_registro6_OutBUS,
        output CC_MATRIXROWWRITER_registro7_OutBUS
    );
endinterface

`default_nettype wire

// File: rtl/cc_matrix_row_writer.sv
// ============================================================================
// Module      : cc_matrix_row_writer
// Description : Loads the 8-row game matrix from a valid/ready stream or
//               clears it one row per cycle; rows are registered outputs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cc_matrix_row_writer #(
    parameter int MATRIXROWWRITER_DATAWIDTH = 8
) (
    input  wire logic              CC_MATRIXROWWRITER_CLOCK_50,
    input  wire logic              CC_MATRIXROWWRITER_RESET_InLow,
    cc_matrix_row_writer_if.slave  bus
);

    localparam int c_num_rows = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [2:0]                           ptr_q, ptr_d;
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] rows_q [c_num_rows];
    logic [MATRIXROWWRITER_DATAWIDTH-1:0] rows_d [c_num_rows];

    always_ff @(posedge CC_MATRIXROWWRITER_CLOCK_50 or negedge CC_MATRIXROWWRITER_RESET_InLow) begin
        if (!CC_MATRIXROWWRITER_RESET_InLow) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            for (int i = 0; i < c_num_rows; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < c_num_rows; i++) begin
                rows_q[i] <= rows_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        for (int i = 0; i < c_num_rows; i++) begin
            rows_d[i] = rows_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                // Clear has priority over start when both are requested.
                if (bus.CC_MATRIXROWWRITER_clear_InHigh) begin
                    state_d = ST_CLEAR;
                    ptr_d   = 3'd0;
                end else if (bus.CC_MATRIXROWWRITER_start_InHigh) begin
                    state_d = ST_LOAD;
                    ptr_d   = 3'd0;
                end
            end
            ST_LOAD: begin
                // ready is high throughout LOAD, so valid alone forms the handshake.
                if (bus.CC_MATRIXROWWRITER_clear_InHigh) begin
                    state_d = ST_CLEAR;
                    ptr_d   = 3'd0;
                end else if (bus.CC_MATRIXROWWRITER_valid_InHigh) begin
                    rows_d[ptr_q] = bus.CC_MATRIXROWWRITER_data_InBUS;
                    ptr_d         = ptr_q + 3'd1;
                    if (ptr_q == 3'd7) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CLEAR: begin
                rows_d[ptr_q] = '0;
                ptr_d         = ptr_q + 3'd1;
                if (ptr_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = 3'd0;
            end
        endcase
    end

    assign bus.CC_MATRIXROWWRITER_ready_OutHigh    = (state_q == ST_LOAD);
    assign bus.CC_MATRIXROWWRITER_busy_OutHigh     = (state_q == ST_LOAD) || (state_q == ST_CLEAR);
    assign bus.CC_MATRIXROWWRITER_done_OutHigh     = (state_q == ST_DONE);
    assign bus.CC_MATRIXROWWRITER_registro0_OutBUS = rows_q[0];
    assign bus.CC_MATRIXROWWRITER_registro1_OutBUS = rows_q[1];
    assign bus.CC_MATRIXROWWRITER_registro2_OutBUS = rows_q[2];
    assign bus.CC_MATRIXROWWRITER_registro3_OutBUS = rows_q[3];
    assign bus.CC_MATRIXROWWRITER_registro4_OutBUS = rows_q[4];
    assign bus.CC_MATRIXROWWRITER_registro5_OutBUS = rows_q[5];
    assign bus.CC_MATRIXROWWRITER_registro6_OutBUS = rows_q[6];
    assign bus.CC_MATRIXROWWRITER_registro7_OutBUS = rows_q[7];

endmodule

`default_nettype wire
